// File: rtl/flash_page_load_arbiter.sv
// Round-robin arbiter that hands the single QSPI flash reader to one cache page at a time,
// forwards that page's reader controls, and writes returned words into the shared cache SRAM.
module flash_page_load_arbiter #(
    parameter int PAGE_COUNT              = 8,
    parameter int PAGE_INDEX_ADDRESS_SIZE = 3,
    parameter int ADDRESS_SIZE            = 24,
    parameter int SRAM_ADDRESS_SIZE       = 9
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [PAGE_COUNT-1:0]                     page_requestLoad,
    input  logic [PAGE_COUNT-1:0]                     page_changeAddress,
    input  logic [PAGE_COUNT-1:0]                     page_requestData,
    input  logic [PAGE_COUNT*ADDRESS_SIZE-1:0]        page_address,
    input  logic [PAGE_COUNT*SRAM_ADDRESS_SIZE-1:0]   page_sramWriteAddress,
    output logic [PAGE_COUNT-1:0]                     page_pageLoading,
    output logic                                      qspi_changeAddress,
    output logic [ADDRESS_SIZE-1:0]                   qspi_address,
    output logic                                      qspi_requestData,
    input  logic [31:0]                               qspi_readData,
    input  logic                                      qspi_readDataValid,
    input  logic                                      qspi_busy,
    output logic                                      sram_writeEnable,
    output logic [SRAM_ADDRESS_SIZE-1:0]              sram_writeAddress,
    output logic [31:0]                               sram_writeData,
    output logic                                      busy,
    output logic [PAGE_INDEX_ADDRESS_SIZE-1:0]        activePage
);

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_LOAD,
        STATE_RELEASE
    } arbState_t;

    arbState_t                          state;
    arbState_t                          nextState;
    logic [PAGE_INDEX_ADDRESS_SIZE-1:0] lastGrant;
    logic [PAGE_INDEX_ADDRESS_SIZE-1:0] pickIndex;
    logic [PAGE_INDEX_ADDRESS_SIZE-1:0] candidate;
    logic                               pickFound;

    // Search starts just after the previous winner; index arithmetic wraps because PAGE_COUNT is a power of two.
    always_comb begin
        pickIndex = lastGrant;
        candidate = lastGrant;
        pickFound = 1'b0;
        for (int i = 1; i <= PAGE_COUNT; i++) begin
            candidate = lastGrant + PAGE_INDEX_ADDRESS_SIZE'(i);
            if (!pickFound && page_requestLoad[candidate]) begin
                pickIndex = candidate;
                pickFound = 1'b1;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= STATE_IDLE;
            activePage <= '0;
            lastGrant  <= PAGE_INDEX_ADDRESS_SIZE'(PAGE_COUNT - 1);
        end else begin
            state <= nextState;
            if (state == STATE_IDLE && nextState == STATE_LOAD) begin
                activePage <= pickIndex;
                lastGrant  <= pickIndex;
            end
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            STATE_IDLE:    if (pickFound && !qspi_busy) nextState = STATE_LOAD;
            STATE_LOAD:    if (!page_requestLoad[activePage]) nextState = STATE_RELEASE;
            STATE_RELEASE: nextState = STATE_IDLE;
            default:       nextState = STATE_IDLE;
        endcase
    end

    // NOTE: every output gets a default before the LOAD branch, so no latch is inferred for the other states.
    always_comb begin
        page_pageLoading   = '0;
        busy               = 1'b0;
        qspi_changeAddress = 1'b0;
        qspi_address       = '0;
        qspi_requestData   = 1'b0;
        sram_writeEnable   = 1'b0;
        sram_writeAddress  = '0;
        sram_writeData     = '0;
        // Gating with rst keeps the reader and SRAM quiet in the reset cycle itself, before the state flop clears.
        if (state == STATE_LOAD && !rst) begin
            page_pageLoading[activePage] = 1'b1;
            busy                         = 1'b1;
            qspi_changeAddress           = page_changeAddress[activePage];
            qspi_address                 = page_address[int'(activePage)*ADDRESS_SIZE +: ADDRESS_SIZE];
            qspi_requestData             = page_requestData[activePage];
            sram_writeEnable             = qspi_readDataValid && page_requestData[activePage];
            sram_writeAddress            = page_sramWriteAddress[int'(activePage)*SRAM_ADDRESS_SIZE +: SRAM_ADDRESS_SIZE];
            sram_writeData               = qspi_readData;
        end
    end

endmodule

// File: tb/tb_flash_page_load_arbiter.sv
// Self-checking bench for flash_page_load_arbiter: directed scenarios plus randomized request
// mixes, checked against a round-robin reference model kept in the bench.
module tb_flash_page_load_arbiter;

    localparam int PC = 8;
    localparam int AW = 24;
    localparam int SW = 9;

    logic            clk;
    logic            rst;
    logic [PC-1:0]   reqLoad;
    logic [PC-1:0]   chg;
    logic [PC-1:0]   reqData;
    logic [PC*AW-1:0] addrBus;
    logic [PC*SW-1:0] sramBus;
    logic [PC-1:0]   pageLoading;
    logic            qChange;
    logic [AW-1:0]   qAddr;
    logic            qReqData;
    logic [31:0]     qData;
    logic            qValid;
    logic            qBusy;
    logic            sWe;
    logic [SW-1:0]   sAddr;
    logic [31:0]     sData;
    logic            busy;
    logic [2:0]      activePage;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int modelLast;
    int written [PC];

    flash_page_load_arbiter dut (
        .clk                   (clk),
        .rst                   (rst),
        .page_requestLoad      (reqLoad),
        .page_changeAddress    (chg),
        .page_requestData      (reqData),
        .page_address          (addrBus),
        .page_sramWriteAddress (sramBus),
        .page_pageLoading      (pageLoading),
        .qspi_changeAddress    (qChange),
        .qspi_address          (qAddr),
        .qspi_requestData      (qReqData),
        .qspi_readData         (qData),
        .qspi_readDataValid    (qValid),
        .qspi_busy             (qBusy),
        .sram_writeEnable      (sWe),
        .sram_writeAddress     (sAddr),
        .sram_writeData        (sData),
        .busy                  (busy),
        .activePage            (activePage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total = total + 1;
        assert (observed === expected) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rule: first requester found walking forward from the previous winner, modulo PAGE_COUNT.
    function automatic int modelPick(input logic [PC-1:0] req, input int last);
        for (int k = 1; k <= PC; k++) begin
            if (req[(last + k) % PC]) return (last + k) % PC;
        end
        return -1;
    endfunction

    function automatic logic [SW-1:0] sramBase(input int p);
        return SW'(p * 128);
    endfunction

    task automatic waitGrant(input string tag, input int expCycles);
        int expPage;
        int n;
        expPage = modelPick(reqLoad, modelLast);
        n = 0;
        do begin
            tick();
            n++;
        end while (!busy && n < 20);
        check({tag, "_latency"}, n, expCycles);
        check({tag, "_page"}, 32'(activePage), expPage);
        check({tag, "_onehot"}, 32'(pageLoading), 32'(1) << expPage);
        modelLast = expPage;
    endtask

    task automatic issueChange(input int p, input logic [AW-1:0] a);
        addrBus[p*AW +: AW] = a;
        chg[p] = 1'b1;
        written[p] = 0;
        #1;
        check("chg_strobe", 32'(qChange), 1);
        check("chg_addr", 32'(qAddr), 32'(a));
        tick();
        chg[p] = 1'b0;
    endtask

    task automatic feedWords(input int p, input int n);
        int done;
        int cycles;
        logic [SW-1:0] expAddr;
        done = 0;
        cycles = 0;
        reqData[p] = 1'b1;
        while (done < n && cycles < 8 * n + 16) begin
            qValid = ($urandom_range(0, 3) != 0);
            qData = $urandom;
            expAddr = sramBase(p) + SW'(written[p]);
            sramBus[p*SW +: SW] = expAddr;
            #1;
            check("fwd_reqdata", 32'(qReqData), 1);
            check("sram_we", 32'(sWe), 32'(qValid));
            if (qValid) begin
                check("sram_addr", 32'(sAddr), 32'(expAddr));
                check("sram_data", sData, qData);
            end
            tick();
            if (qValid) begin
                done++;
                written[p]++;
            end
            cycles++;
        end
        check("words_done", done, n);
        qValid = 1'b0;
    endtask

    // Completes a fill and ends in the RELEASE cycle, checking that stray data there is ignored.
    task automatic doFill(input int p, input logic [AW-1:0] a, input int n);
        issueChange(p, a);
        feedWords(p, n);
        reqData[p] = 1'b0;
        reqLoad[p] = 1'b0;
        #1;
        check("still_granted", 32'(busy), 1);
        tick();
        reqData[p] = 1'b1;
        qValid = 1'b1;
        qData = 32'hDEADBEEF;
        #1;
        check("release_grant", 32'(pageLoading), 0);
        check("release_busy", 32'(busy), 0);
        check("release_we", 32'(sWe), 0);
        check("release_reqdata", 32'(qReqData), 0);
        reqData[p] = 1'b0;
        qValid = 1'b0;
    endtask

    initial begin
        int mask;
        rst = 1'b1;
        reqLoad = '0;
        chg = '0;
        reqData = '0;
        addrBus = '0;
        sramBus = '0;
        qData = 32'hDEADBEEF;
        qValid = 1'b1;
        qBusy = 1'b0;
        modelLast = PC - 1;
        foreach (written[i]) written[i] = 0;
        tick();
        tick();
        check("rst_grant", 32'(pageLoading), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_active", 32'(activePage), 0);
        check("rst_we", 32'(sWe), 0);
        qValid = 1'b0;
        rst = 1'b0;
        tick();

        // Single page fill of 128 words.
        reqLoad[3] = 1'b1;
        #1;
        check("t1_pre_grant", 32'(pageLoading), 0);
        waitGrant("t1", 1);
        doFill(3, 24'h001800, 128);
        tick();
        qValid = 1'b1;
        reqData = '1;
        #1;
        check("idle_we", 32'(sWe), 0);
        check("idle_busy", 32'(busy), 0);
        qValid = 1'b0;
        reqData = '0;

        // Three simultaneous requesters from a fresh reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelLast = PC - 1;
        reqLoad = 8'b0010_0101;
        waitGrant("t2_first", 1);
        doFill(modelLast, 24'h000100, 4);
        waitGrant("t2_second", 2);
        doFill(modelLast, 24'h000200, 3);
        waitGrant("t2_third", 2);
        doFill(modelLast, 24'h000300, 5);

        // Continuous requester must yield to the other pending page.
        tick();
        reqLoad[1] = 1'b1;
        waitGrant("t3_p1", 1);
        reqLoad[6] = 1'b1;
        doFill(1, 24'h010000, 3);
        reqLoad[1] = 1'b1;
        waitGrant("t3_p6", 2);
        check("t3_fair", 32'(activePage), 6);
        doFill(6, 24'h060000, 2);
        waitGrant("t3_p1_again", 2);
        doFill(1, 24'h010100, 2);

        // Random request mixes held off by qspi_busy.
        for (int r = 0; r < 6; r++) begin
            mask = $urandom_range(1, 255);
            reqLoad = 8'(mask);
            qBusy = 1'b1;
            for (int h = 0; h < int'($urandom_range(1, 3)); h++) begin
                tick();
                check("hold_busy", 32'(busy), 0);
                check("hold_grant", 32'(pageLoading), 0);
            end
            qBusy = 1'b0;
            waitGrant("rand_first", 1);
            doFill(modelLast, 24'($urandom), $urandom_range(1, 6));
            while (reqLoad != 0) begin
                waitGrant("rand_next", 2);
                doFill(modelLast, 24'($urandom), $urandom_range(1, 6));
            end
        end

        // Reset in the middle of a page 4 fill.
        tick();
        reqLoad = 8'b0001_0000;
        waitGrant("t5_p4", 1);
        issueChange(4, 24'h040000);
        feedWords(4, 40);
        rst = 1'b1;
        reqData[4] = 1'b1;
        qValid = 1'b1;
        #1;
        check("t5_rst_we_now", 32'(sWe), 0);
        tick();
        check("t5_grant", 32'(pageLoading), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_reqdata", 32'(qReqData), 0);
        check("t5_we", 32'(sWe), 0);
        check("t5_active", 32'(activePage), 0);
        rst = 1'b0;
        reqData = '0;
        qValid = 1'b0;
        modelLast = PC - 1;
        reqLoad = 8'b0001_0001;
        waitGrant("t5_p0", 1);
        check("t5_p0_wins", 32'(activePage), 0);
        doFill(0, 24'h000000, 2);
        waitGrant("t5_p4_after", 2);
        doFill(4, 24'h040000, 2);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
